// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit that sits directly behind the ID/EX
//   pipeline register. It computes MUL/MULH/MULHSU/MULHU with a 32-step
//   shift-add on operand magnitudes and DIV/DIVU/REM/REMU with a 32-step
//   restoring divider. Divide-by-zero and signed overflow finish in a
//   single cycle. While an operation is in flight, a combinational stall
//   holds the front of the pipeline. When the operation finishes, the result
//   is presented with a one-cycle done pulse.
//
//   Build option: define MULDIV_FAST_MUL_EN to compute all multiplies with
//   one 64-bit multiply in a single cycle. Results are the same in both
//   builds; only the latency changes.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   clr       flush from the hazard unit; aborts CALC and blocks a start
//   start     ID/EX holds a valid M-extension instruction
//   func3_in  RV32M func3 (000 MUL .. 111 REMU)
//   op_a      rs1 value
//   op_b      rs2 value
//   rd_in     destination register
//   stall_out combinational stall request to the hazard unit
//   busy      registered, high while iterating
//   done      registered one-cycle result-valid pulse
//   result    registered result, held until the next done
//   rd_out    registered destination register captured at start
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  start,
    input  logic [2:0]            func3_in,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [REG_WIDTH-1:0]  rd_in,
    output logic                  stall_out,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [REG_WIDTH-1:0]  rd_out
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);
    localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2:0]          func3_q, func3_d;
    logic [2*DW-1:0]     p_q, p_d;          // {partial product | remainder, multiplier | quotient}
    logic [DW-1:0]       b_mag_q, b_mag_d;
    logic                neg_q, neg_d;      // negate product / quotient at the end
    logic                rem_neg_q, rem_neg_d;
    logic [DW-1:0]       result_q, result_d;
    logic [REG_WIDTH-1:0] rd_q, rd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // ---------------- input decode ----------------
    logic          is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic [DW-1:0] a_mag_in, b_mag_in;
    logic          div_by_zero, div_ovf, special_in;
    logic [DW-1:0] special_res;

    assign is_div_in   = func3_in[2];
    // Divides: bit0 clear means signed. Multiplies: MUL/MULH/MULHSU sign op_a,
    // MUL/MULH sign op_b.
    assign a_signed_in = is_div_in ? ~func3_in[0] : (func3_in[1:0] != 2'b11);
    assign b_signed_in = is_div_in ? ~func3_in[0] : ~func3_in[1];
    assign a_neg_in    = a_signed_in & op_a[DW-1];
    assign b_neg_in    = b_signed_in & op_b[DW-1];
    assign a_mag_in    = a_neg_in ? ({DW{1'b0}} - op_a) : op_a;
    assign b_mag_in    = b_neg_in ? ({DW{1'b0}} - op_b) : op_b;

    assign div_by_zero = is_div_in & (op_b == {DW{1'b0}});
    assign div_ovf     = is_div_in & ~func3_in[0] & (op_a == MIN_NEG) & (op_b == {DW{1'b1}});
    assign special_in  = div_by_zero | div_ovf;
    // func3[1] selects remainder over quotient.
    assign special_res = div_by_zero ? (func3_in[1] ? op_a : {DW{1'b1}})
                                     : (func3_in[1] ? {DW{1'b0}} : MIN_NEG);

    // ---------------- optional single-cycle multiply ----------------
    logic          fast_hit;
    logic [DW-1:0] fast_res;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*DW-1:0] a_ext, b_ext, fast_prod;
    assign a_ext     = {{DW{a_neg_in}}, op_a};
    assign b_ext     = {{DW{b_neg_in}}, op_b};
    // The low 2*DW bits of the sign/zero-extended product are exact.
    assign fast_prod = a_ext * b_ext;
    assign fast_hit  = ~is_div_in;
    assign fast_res  = (func3_in[1:0] == 2'b00) ? fast_prod[DW-1:0] : fast_prod[2*DW-1:DW];
`else
    assign fast_hit  = 1'b0;
    assign fast_res  = {DW{1'b0}};
`endif

    // ---------------- one iteration ----------------
    logic [DW:0]     mul_sum, rem_sh, div_diff;
    logic            div_ge;
    logic [2*DW-1:0] mul_step, div_step, step, prod_fix;
    logic [DW-1:0]   quo_fix, rem_fix, final_res;

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole register right.
    assign mul_sum  = {1'b0, p_q[2*DW-1:DW]} + {1'b0, b_mag_q};
    assign mul_step = p_q[0] ? {mul_sum, p_q[DW-1:1]}
                             : {1'b0, p_q[2*DW-1:DW], p_q[DW-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder. Then
    // subtract the divisor if it fits. Quotient bits enter at the bottom.
    assign rem_sh   = p_q[2*DW-1:DW-1];
    assign div_diff = rem_sh - {1'b0, b_mag_q};
    assign div_ge   = (rem_sh >= {1'b0, b_mag_q});
    assign div_step = div_ge ? {div_diff[DW-1:0], p_q[DW-2:0], 1'b1}
                             : {rem_sh[DW-1:0],   p_q[DW-2:0], 1'b0};

    assign step     = func3_q[2] ? div_step : mul_step;

    assign prod_fix = neg_q ? ({(2*DW){1'b0}} - step) : step;
    assign quo_fix  = neg_q ? ({DW{1'b0}} - step[DW-1:0]) : step[DW-1:0];
    assign rem_fix  = rem_neg_q ? ({DW{1'b0}} - step[2*DW-1:DW]) : step[2*DW-1:DW];
    assign final_res = func3_q[2] ? (func3_q[1] ? rem_fix : quo_fix)
                                  : ((func3_q[1:0] == 2'b00) ? prod_fix[DW-1:0]
                                                             : prod_fix[2*DW-1:DW]);

    // ---------------- next state ----------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        func3_d   = func3_q;
        p_d       = p_q;
        b_mag_d   = b_mag_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        rd_d      = rd_q;
        case (state_q)
            IDLE: begin
                if (start && !clr) begin
                    func3_d   = func3_in;
                    rd_d      = rd_in;
                    count_d   = '0;
                    b_mag_d   = b_mag_in;
                    p_d       = {{DW{1'b0}}, a_mag_in};
                    neg_d     = a_neg_in ^ b_neg_in;
                    rem_neg_d = a_neg_in;
                    if (special_in) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else if (fast_hit) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (clr) begin
                    state_d = IDLE;
                end else begin
                    p_d     = step;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_CNT) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            func3_q   <= '0;
            p_q       <= '0;
            b_mag_q   <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            func3_q   <= func3_d;
            p_q       <= p_d;
            b_mag_q   <= b_mag_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign stall_out = ((state_q == IDLE) & start & ~clr) | ((state_q == CALC) & ~clr);
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign rd_out    = rd_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit. Expected results come from a
// reference model or from constants. They are queued when an operation is
// issued and are popped when done is seen.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, clr, start;
    logic [2:0]  func3_in;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  rd_in, rd_out;
    logic        stall_out, busy, done;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res = 32'h0;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          edges;
    } exp_t;

    exp_t sb_q[$];

    ex_muldiv_unit #(.DATA_WIDTH(32), .REG_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .func3_in(func3_in),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall_out(stall_out),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, sa, sb, p;
        int ia, ib;
        logic [31:0] r;
        ua = {32'h0, a}; ub = {32'h0, b};
        sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
        ia = a; ib = b;
        r = 32'h0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(ia / ib));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Edges from the accepting edge (counted as 1) until done is visible.
    function automatic int exp_edges(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Called just after a rising edge with the unit in IDLE. Returns just after the accepting edge.
    task automatic send_op(input op_t op, input bit track, output int pre_stall);
        exp_t e;
        start = 1'b1; func3_in = op.f; op_a = op.a; op_b = op.b; rd_in = op.rd;
        #1;
        pre_stall = int'(stall_out);
        if (track) begin
            e.res = op.exp; e.rd = op.rd; e.edges = exp_edges(op.f, op.a, op.b);
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom); func3_in = 3'($urandom);
    endtask

    // Waits (bounded) for done; returns just after the edge leaving DONE.
    task automatic collect(output bit got, output int edges, output int stalls,
                           output logic [31:0] res, output logic [4:0] rd, output logic done_after);
        got = 1'b0; edges = 1; stalls = 0; res = '0; rd = '0; done_after = 1'b1;
        while (edges <= 80) begin
            if (done === 1'b1) begin got = 1'b1; res = result; rd = rd_out; break; end
            if (stall_out === 1'b1) stalls++;
            @(posedge clk); #1;
            edges++;
        end
        if (got) begin @(posedge clk); #1; done_after = done; end
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b0; start = 1'b0; func3_in = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({busy, done, stall_out} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: busy/done/stall=%b want 000", {busy, done, stall_out}); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
        total++; if (rd_out !== 5'd0) begin bad++; $display("FAIL reset_rd: got %0d want 0", rd_out); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        op_t ops[$];
        exp_t e;
        int pre, edges, stalls;
        bit got;
        logic [31:0] res;
        logic [4:0] rd;
        logic da;
        ops.push_back(op_t'{3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB});
        ops.push_back(op_t'{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE});
        for (int k = 0; k < 8; k++) begin
            op_t o;
            o.f = 3'(k % 4); o.a = $urandom; o.b = $urandom; o.rd = 5'($urandom);
            o.exp = ref_model(o.f, o.a, o.b);
            ops.push_back(o);
        end
        foreach (ops[i]) begin
            send_op(ops[i], 1'b1, pre);
            collect(got, edges, stalls, res, rd, da);
            e = sb_q.pop_front();
            total++;
            if (!got) begin bad++; $display("FAIL mul_timeout[%0d]: no done within 80 edges, want done", i); end
            else begin
                total++; if (res !== e.res) begin bad++; $display("FAIL mul_result[%0d] f=%0d a=%h b=%h: got %h want %h", i, ops[i].f, ops[i].a, ops[i].b, res, e.res); end
                total++; if (rd !== e.rd) begin bad++; $display("FAIL mul_rd[%0d]: got %0d want %0d", i, rd, e.rd); end
                total++; if (edges != e.edges) begin bad++; $display("FAIL mul_latency[%0d]: got %0d edges want %0d", i, edges, e.edges); end
                total++; if (pre + stalls != ((e.edges == 1) ? 1 : 33)) begin bad++; $display("FAIL mul_stall[%0d]: got %0d cycles want %0d", i, pre + stalls, (e.edges == 1) ? 1 : 33); end
                total++; if (da !== 1'b0) begin bad++; $display("FAIL mul_done_pulse[%0d]: done after DONE=%b want 0", i, da); end
                last_res = e.res;
            end
        end
    endtask

    task automatic test_div;
        op_t ops[$];
        exp_t e;
        int pre, edges, stalls;
        bit got;
        logic [31:0] res;
        logic [4:0] rd;
        logic da;
        ops.push_back(op_t'{3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD});
        ops.push_back(op_t'{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF});
        ops.push_back(op_t'{3'd5, 32'd100, 32'd7, 5'd3, 32'd14});
        ops.push_back(op_t'{3'd7, 32'd100, 32'd7, 5'd4, 32'd2});
        for (int k = 0; k < 8; k++) begin
            op_t o;
            o.f = 3'(4 + k % 4); o.a = $urandom; o.b = (k == 5) ? 32'($urandom_range(1, 99)) : $urandom;
            o.rd = 5'($urandom);
            o.exp = ref_model(o.f, o.a, o.b);
            ops.push_back(o);
        end
        foreach (ops[i]) begin
            send_op(ops[i], 1'b1, pre);
            collect(got, edges, stalls, res, rd, da);
            e = sb_q.pop_front();
            total++;
            if (!got) begin bad++; $display("FAIL div_timeout[%0d]: no done within 80 edges, want done", i); end
            else begin
                total++; if (res !== e.res) begin bad++; $display("FAIL div_result[%0d] f=%0d a=%h b=%h: got %h want %h", i, ops[i].f, ops[i].a, ops[i].b, res, e.res); end
                total++; if (rd !== e.rd) begin bad++; $display("FAIL div_rd[%0d]: got %0d want %0d", i, rd, e.rd); end
                total++; if (edges != e.edges) begin bad++; $display("FAIL div_latency[%0d]: got %0d edges want %0d", i, edges, e.edges); end
                total++; if (pre + stalls != ((e.edges == 1) ? 1 : 33)) begin bad++; $display("FAIL div_stall[%0d]: got %0d cycles want %0d", i, pre + stalls, (e.edges == 1) ? 1 : 33); end
                last_res = e.res;
            end
        end
    endtask

    task automatic test_special;
        op_t ops[$];
        exp_t e;
        int pre, edges, stalls;
        bit got;
        logic [31:0] res;
        logic [4:0] rd;
        logic da;
        ops.push_back(op_t'{3'd5, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF});
        ops.push_back(op_t'{3'd6, 32'd5, 32'd0, 5'd11, 32'd5});
        ops.push_back(op_t'{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000});
        ops.push_back(op_t'{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0});
        foreach (ops[i]) begin
            send_op(ops[i], 1'b1, pre);
            collect(got, edges, stalls, res, rd, da);
            e = sb_q.pop_front();
            total++;
            if (!got) begin bad++; $display("FAIL special_timeout[%0d]: no done within 80 edges, want done", i); end
            else begin
                total++; if (res !== e.res) begin bad++; $display("FAIL special_result[%0d]: got %h want %h", i, res, e.res); end
                total++; if (rd !== e.rd) begin bad++; $display("FAIL special_rd[%0d]: got %0d want %0d", i, rd, e.rd); end
                total++; if (edges != 1) begin bad++; $display("FAIL special_latency[%0d]: got %0d edges want 1", i, edges); end
                total++; if (pre + stalls != 1) begin bad++; $display("FAIL special_stall[%0d]: got %0d cycles want 1", i, pre + stalls); end
                total++; if (da !== 1'b0) begin bad++; $display("FAIL special_done_pulse[%0d]: got %b want 0", i, da); end
                last_res = e.res;
            end
        end
    endtask

    task automatic test_flush;
        int pre, pulses;
        // Abort a DIV in the middle of its iterations.
        send_op(op_t'{3'd4, 32'd1000, 32'd3, 5'd20, 32'd333}, 1'b0, pre);
        repeat (9) @(posedge clk);
        #1; clr = 1'b1; #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall_out); end
        @(posedge clk); #1; clr = 1'b0;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL flush_idle: busy/done=%b want 00", {busy, done}); end
        total++; if (result !== last_res) begin bad++; $display("FAIL flush_result: got %h want %h", result, last_res); end
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) pulses++; end
        total++; if (pulses != 0) begin bad++; $display("FAIL flush_no_done: %0d active cycles want 0", pulses); end
        // start together with clr is dropped.
        start = 1'b1; clr = 1'b1; func3_in = 3'd5; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd21;
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL startclr_stall: got %b want 0", stall_out); end
        @(posedge clk); #1; start = 1'b0; clr = 1'b0;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) pulses++; end
        total++; if (pulses != 0) begin bad++; $display("FAIL startclr_accept: %0d active cycles want 0", pulses); end
        total++; if (result !== last_res) begin bad++; $display("FAIL startclr_result: got %h want %h", result, last_res); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int pre, edges, stalls, pulses;
        bit got;
        logic [31:0] res;
        logic [4:0] rd;
        logic da;
        pulses = 0;
        send_op(op_t'{3'd0, 32'd12, 32'd11, 5'd6, 32'd132}, 1'b1, pre);
        collect(got, edges, stalls, res, rd, da);
        e = sb_q.pop_front();
        if (got) pulses++;
        total++; if (res !== e.res) begin bad++; $display("FAIL b2b_mul_result: got %h want %h", res, e.res); end
        total++; if (edges != e.edges) begin bad++; $display("FAIL b2b_mul_latency: got %0d want %0d", edges, e.edges); end
        // Issued on the cycle right after the edge leaving DONE.
        send_op(op_t'{3'd4, 32'hFFFF_FF9C, 32'd7, 5'd7, 32'hFFFF_FFF2}, 1'b1, pre);
        collect(got, edges, stalls, res, rd, da);
        e = sb_q.pop_front();
        if (got) pulses++;
        total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        total++; if (res !== e.res) begin bad++; $display("FAIL b2b_div_result: got %h want %h", res, e.res); end
        total++; if (rd !== e.rd) begin bad++; $display("FAIL b2b_div_rd: got %0d want %0d", rd, e.rd); end
        total++; if (edges != 33) begin bad++; $display("FAIL b2b_div_latency: got %0d edges after leaving DONE want 33", edges); end
        if (got) last_res = e.res;
    endtask

    task automatic test_reset_mid;
        int pre, pulses;
        send_op(op_t'{3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 32'h0}, 1'b0, pre);
        repeat (5) @(posedge clk);
        #2; rst = 1'b1; #1;
        total++; if ({busy, done, stall_out} !== 3'b000) begin bad++; $display("FAIL midreset_ctrl: busy/done/stall=%b want 000", {busy, done, stall_out}); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL midreset_result: got %h want 00000000", result); end
        total++; if (rd_out !== 5'd0) begin bad++; $display("FAIL midreset_rd: got %0d want 0", rd_out); end
        @(posedge clk); #1; rst = 1'b0;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
        total++; if (pulses != 0) begin bad++; $display("FAIL midreset_no_done: %0d pulses want 0", pulses); end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_special;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
